// File: rtl/spi_bridge_pkg.sv
// Shared types and constants for the SPI bridge command-FIFO write path.
package spi_bridge_pkg;

  typedef enum logic [0:0] {
    IDLE,
    LOCKED
  } arb_state_t;

  localparam int unsigned FIFO_DATA_WIDTH = 41;
  localparam int unsigned STAT_WIDTH      = 16;

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: the first asserted request at or after
// last_owner+1 (mod NUM_REQ) wins.
module rr_pick
  import spi_bridge_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_owner,
  output logic               hit,
  output logic [IDX_W-1:0]   index
);

  logic [31:0] cand;

  // Scan from the farthest candidate to the nearest so the nearest hit overwrites.
  always_comb begin
    hit   = 1'b0;
    index = '0;
    cand  = '0;
    for (int off = NUM_REQ; off >= 1; off--) begin
      cand = (32'(last_owner) + 32'(off)) % NUM_REQ;
      if (req[cand[IDX_W-1:0]]) begin
        hit   = 1'b1;
        index = cand[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-locking arbiter sharing the command-FIFO write port.
// Optional feature macro: ARB_STATS_EN (per-requester beat and stall counters).
module fifo_wr_arbiter
  import spi_bridge_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned MAX_BURST  = 4,
  localparam int unsigned ID_W      = $clog2(NUM_REQ),
  localparam int unsigned CNT_W     = $clog2(MAX_BURST) + 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
  input  logic [NUM_REQ-1:0]              req_last,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic                            fifo_full,
  output logic                            fifo_wr_en,
  output logic [DATA_WIDTH-1:0]           fifo_wr_data,
  output logic [ID_W-1:0]                 grant_id,
  output logic                            busy,
  output logic [NUM_REQ*STAT_WIDTH-1:0]   stat_beats,
  output logic [STAT_WIDTH-1:0]           stat_stall
);

  arb_state_t             state_q, state_d;
  logic [ID_W-1:0]        owner_q, owner_d;
  logic [ID_W-1:0]        last_owner_q, last_owner_d;
  logic [CNT_W-1:0]       beat_cnt_q, beat_cnt_d;
  logic                   owner_valid, owner_last;
  logic [DATA_WIDTH-1:0]  owner_data;
  logic                   pick_hit;
  logic [ID_W-1:0]        pick_idx;
  logic                   accept;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (ID_W)
  ) u_rr_pick (
    .req        (req_valid),
    .last_owner (last_owner_q),
    .hit        (pick_hit),
    .index      (pick_idx)
  );

  // Select the current owner's valid/last/data.
  always_comb begin
    owner_valid = 1'b0;
    owner_last  = 1'b0;
    owner_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner_q == ID_W'(i)) begin
        owner_valid = req_valid[i];
        owner_last  = req_last[i];
        owner_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign accept = (state_q == LOCKED) && owner_valid && !fifo_full;

  // Next-state: grant on a round-robin hit, release after the burst ends.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    beat_cnt_d   = beat_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (pick_hit) begin
          state_d    = LOCKED;
          owner_d    = pick_idx;
          beat_cnt_d = '0;
        end
      end
      LOCKED: begin
        if (accept && (beat_cnt_q != CNT_W'(MAX_BURST))) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
        end
        // Owner gone, or its last/burst-limit word accepted this cycle.
        if (!owner_valid ||
            (accept && (owner_last || (beat_cnt_q == CNT_W'(MAX_BURST - 1))))) begin
          state_d      = IDLE;
          last_owner_d = owner_q;
          owner_d      = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Write-port outputs; full gates ready and write enable combinationally.
  always_comb begin
    req_ready    = '0;
    fifo_wr_en   = 1'b0;
    fifo_wr_data = '0;
    if (state_q == LOCKED) begin
      req_ready[owner_q] = !fifo_full;
      fifo_wr_en         = owner_valid && !fifo_full;
      fifo_wr_data       = owner_data;
    end
  end

  assign busy     = (state_q == LOCKED);
  assign grant_id = owner_q;

  // Arbiter state registers; last_owner resets so requester 0 wins first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      owner_q      <= '0;
      last_owner_q <= ID_W'(NUM_REQ - 1);
      beat_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      beat_cnt_q   <= beat_cnt_d;
    end
  end

`ifdef ARB_STATS_EN
  logic [NUM_REQ-1:0][STAT_WIDTH-1:0] beats_q;
  logic [STAT_WIDTH-1:0]              stall_q;
  logic                               stall;

  assign stall = (state_q == LOCKED) && owner_valid && fifo_full;

  // Saturating per-requester beat counters and full-stall counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beats_q <= '0;
      stall_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (accept && (owner_q == ID_W'(i)) && (beats_q[i] != '1)) begin
          beats_q[i] <= beats_q[i] + 1'b1;
        end
      end
      if (stall && (stall_q != '1)) begin
        stall_q <= stall_q + 1'b1;
      end
    end
  end

  assign stat_beats = beats_q;
  assign stat_stall = stall_q;
`else
  assign stat_beats = '0;
  assign stat_stall = '0;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter with a write-order scoreboard.
module tb_fifo_wr_arbiter;

  localparam int unsigned DW = 41;
  localparam int unsigned NR = 2;
  localparam int unsigned MB = 4;

  logic              clk;
  logic              rst_n;
  logic [NR-1:0]     req_valid;
  logic [NR*DW-1:0]  req_data;
  logic [NR-1:0]     req_last;
  logic [NR-1:0]     req_ready;
  logic              fifo_full;
  logic              fifo_wr_en;
  logic [DW-1:0]     fifo_wr_data;
  logic [0:0]        grant_id;
  logic              busy;
  logic [NR*16-1:0]  stat_beats;
  logic [15:0]       stat_stall;

  int checks = 0;
  int errors = 0;
  int rem[NR];
  int seq[NR];
  logic [NR-1:0] last_en;
  logic [DW-1:0] exp_q[$];

  fifo_wr_arbiter #(
    .DATA_WIDTH (DW),
    .NUM_REQ    (NR),
    .MAX_BURST  (MB)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_last     (req_last),
    .req_ready    (req_ready),
    .fifo_full    (fifo_full),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_wr_data (fifo_wr_data),
    .grant_id     (grant_id),
    .busy         (busy),
    .stat_beats   (stat_beats),
    .stat_stall   (stat_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] word(input int r, input int s);
    logic [7:0]  rb;
    logic [31:0] sb;
    rb = 8'(r);
    sb = 32'(s);
    return {1'b1, rb, sb};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Requester models: drive the head word of each pending burst.
  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      req_valid[i]              = (rem[i] > 0);
      req_last[i]               = last_en[i] && (rem[i] == 1);
      req_data[i*DW +: DW]      = word(i, seq[i]);
    end
  endtask

  task automatic push(input int r, input int off, input int n);
    for (int k = 0; k < n; k++) exp_q.push_back(word(r, seq[r] + off + k));
  endtask

  // One cycle: sample mid-cycle, score any write, then advance accepted requesters.
  task automatic tick(input bit chk, input logic eb, input logic [0:0] eg, input logic ew);
    logic [NR-1:0] acc;
    logic [NR-1:0] exp_rdy;
    @(negedge clk);
    if (chk) begin
      exp_rdy = '0;
      if (eb && !fifo_full) exp_rdy[eg] = 1'b1;
      check("busy", busy, eb);
      check("grant_id", grant_id, eg);
      check("fifo_wr_en", fifo_wr_en, ew);
      check("req_ready", req_ready, exp_rdy);
    end
    if (fifo_wr_en) begin
      if (exp_q.size() == 0) check("wr_unexpected", fifo_wr_en, 1'b0);
      else check("wr_data", fifo_wr_data, exp_q.pop_front());
    end
    acc = req_valid & req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++) begin
      if (acc[i]) begin
        rem[i]--;
        seq[i]++;
      end
    end
    drive();
  endtask

  task automatic expect_n(input int n, input logic eb, input logic [0:0] eg, input logic ew);
    repeat (n) tick(1'b1, eb, eg, ew);
  endtask

  task automatic run_until_idle(input int budget);
    int n;
    n = 0;
    while (((rem[0] != 0) || (rem[1] != 0) || busy) && (n < budget)) begin
      tick(1'b0, 1'b0, 1'b0, 1'b0);
      n++;
    end
    check("drain_done", ((rem[0] == 0) && (rem[1] == 0) && !busy), 1'b1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_req_ready"}, req_ready, '0);
    check({tag, "_wr_en"}, fifo_wr_en, 1'b0);
    check({tag, "_wr_data"}, fifo_wr_data, '0);
    check({tag, "_grant_id"}, grant_id, '0);
    check({tag, "_busy"}, busy, 1'b0);
  endtask

  initial begin
    rst_n     = 1'b0;
    fifo_full = 1'b0;
    last_en   = '0;
    for (int i = 0; i < NR; i++) begin
      rem[i] = 0;
      seq[i] = 0;
    end
    drive();

    // Reset state
    #12;
    check_idle_outputs("reset");
    check("reset_stat_beats", stat_beats, '0);
    check("reset_stat_stall", stat_stall, '0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;

    // Both requesters, no last: 4-word bursts alternating with one idle cycle
    rem[0] = 8;
    rem[1] = 8;
    push(0, 0, 4); push(1, 0, 4); push(0, 4, 4); push(1, 4, 4);
    drive();
    expect_n(1, 0, 0, 0);
    expect_n(4, 1, 0, 1); expect_n(1, 0, 0, 0);
    expect_n(4, 1, 1, 1); expect_n(1, 0, 0, 0);
    expect_n(4, 1, 0, 1); expect_n(1, 0, 0, 0);
    expect_n(4, 1, 1, 1); expect_n(1, 0, 0, 0);
    check("q_empty_rr", exp_q.size(), 0);

    // Requester 1: two words ending in req_last
    rem[1]  = 2;
    last_en = 2'b10;
    push(1, 0, 2);
    drive();
    expect_n(1, 0, 0, 0);
    expect_n(2, 1, 1, 1);
    expect_n(1, 0, 0, 0);
    check("q_empty_last", exp_q.size(), 0);

    // Full stall mid-burst, plus a competing request that must wait
    last_en = '0;
    rem[0]  = 4;
    push(0, 0, 4);
    drive();
    expect_n(1, 0, 0, 0);
    expect_n(1, 1, 0, 1);
    rem[1] = 1;
    push(1, 0, 1);
    drive();
    expect_n(1, 1, 0, 1);
    fifo_full = 1'b1;
    expect_n(3, 1, 0, 0);
    fifo_full = 1'b0;
    expect_n(2, 1, 0, 1);
    expect_n(1, 0, 0, 0);
    expect_n(1, 1, 1, 1);
    expect_n(1, 1, 1, 0);
    expect_n(1, 0, 0, 0);
    check("q_empty_stall", exp_q.size(), 0);
`ifdef ARB_STATS_EN
    check("stat_stall_3", stat_stall, 16'd3);
    check("stat_beats0_12", stat_beats[15:0], 16'd12);
    check("stat_beats1_11", stat_beats[31:16], 16'd11);
`else
    check("stat_beats_tied", stat_beats, '0);
    check("stat_stall_tied", stat_stall, '0);
`endif

    // Owner drops valid after one word; the other requester follows
    rem[0] = 1;
    rem[1] = 2;
    push(0, 0, 1); push(1, 0, 2);
    drive();
    expect_n(1, 0, 0, 0);
    expect_n(1, 1, 0, 1);
    expect_n(1, 1, 0, 0);
    expect_n(1, 0, 0, 0);
    expect_n(2, 1, 1, 1);
    expect_n(1, 1, 1, 0);
    expect_n(1, 0, 0, 0);
    check("q_empty_drop", exp_q.size(), 0);

    // Make requester 0 the last owner, then reset mid-burst of requester 1
    rem[0]  = 1;
    last_en = 2'b01;
    push(0, 0, 1);
    drive();
    expect_n(1, 0, 0, 0);
    expect_n(1, 1, 0, 1);
    rem[1] = 4;
    push(1, 0, 4);
    drive();
    expect_n(1, 0, 0, 0);
    expect_n(2, 1, 1, 1);
    #3;
    rst_n = 1'b0;
    #1;
    check_idle_outputs("rst_async");
    exp_q.delete();
    rem[0] = 0;
    rem[1] = 0;
    drive();
    @(posedge clk);
    #1;
    check_idle_outputs("rst_held");
    check("rst_stat_stall", stat_stall, '0);
    #2;
    rst_n = 1'b1;
    rem[0]  = 2;
    rem[1]  = 2;
    last_en = 2'b11;
    push(0, 0, 2); push(1, 0, 2);
    drive();
    expect_n(1, 0, 0, 0);
    expect_n(2, 1, 0, 1);
    expect_n(1, 0, 0, 0);
    expect_n(2, 1, 1, 1);
    expect_n(1, 0, 0, 0);
    check("q_empty_reset", exp_q.size(), 0);

`ifdef ARB_STATS_EN
    // Long stream from requester 0 saturates its beat counter
    last_en = '0;
    rem[0]  = 65540;
    push(0, 0, 65540);
    drive();
    run_until_idle(90000);
    check("q_empty_sat", exp_q.size(), 0);
    check("stat_beats0_sat", stat_beats[15:0], 16'hFFFF);
    check("stat_beats1_post_rst", stat_beats[31:16], 16'd2);
    check("stat_stall_post_rst", stat_stall, 16'd0);
`else
    check("stat_beats_tied_end", stat_beats, '0);
    check("stat_stall_tied_end", stat_stall, '0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
